// File: rtl/garota_mr_pkg.sv
// ---------------------------------------------------------------------------
// garota_mr_pkg
// Shared types and helpers for the multi-region GAROTA monitor.
//   state_t    : monitor FSM encoding (ARMED=0, HOLD=1, WAIT_RH=2)
//   cause_*    : bit positions inside the viol_cause vector, which packs
//                {atom, gie, irq, rgn[NUM_REGIONS-1:0]} from MSB down to LSB.
// ---------------------------------------------------------------------------
package garota_mr_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_RH = 2'd2
    } state_t;

    // Cause bit indices. Region bits occupy [num_regions-1:0].
    function automatic int cause_irq(input int num_regions);
        return num_regions;
    endfunction

    function automatic int cause_gie(input int num_regions);
        return num_regions + 1;
    endfunction

    function automatic int cause_atom(input int num_regions);
        return num_regions + 2;
    endfunction

endpackage

// File: rtl/garota_mr_region_chk.sv
// ---------------------------------------------------------------------------
// garota_region_chk
// Combinational window compare: hit = (base <= addr < base + size).
// The upper bound is formed in ADDR_W+1 bits so a window that ends exactly
// at the top of the address space does not wrap to zero. A zero size marks
// the window as disabled and never hits.
// Ports:
//   addr  in  ADDR_W  address under test
//   base  in  ADDR_W  window start
//   size  in  ADDR_W  window length (0 = disabled)
//   hit   out 1       address falls inside the window
// ---------------------------------------------------------------------------
module garota_region_chk #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    output logic              hit
);

    logic [ADDR_W:0] addr_x;
    logic [ADDR_W:0] lo_x;
    logic [ADDR_W:0] hi_x;

    assign addr_x = {1'b0, addr};
    assign lo_x   = {1'b0, base};
    assign hi_x   = {1'b0, base} + {1'b0, size};

    assign hit = (size != '0) && (addr_x >= lo_x) && (addr_x < hi_x);

endmodule

// File: rtl/garota_mr.sv
// ---------------------------------------------------------------------------
// garota_mr
// Multi-region GAROTA monitor. Protects NUM_REGIONS data windows against
// writes from code outside the TCB and against any DMA access, forbids
// interrupts/DMA/GIE while the PC is inside the TCB, and enforces that the
// TCB is only entered at TCB_BASE and only left from TCB_EXIT. Any violation
// raises a registered reset that is held for at least RST_HOLD+1 cycles and
// released only once the PC reaches RESET_HANDLER.
//
// Optional feature (macro GAROTA_MR_VIOL_LOG_EN):
//   defined   : sticky first-violation cause vector and saturating event
//               counter are kept; both clear only on rst_n.
//   undefined : viol_cause and viol_cnt are constant zero.
//
// Ports:
//   clk         in   1               system clock
//   rst_n       in   1               async active-low reset
//   pc          in   ADDR_W          current PC
//   data_wr     in   1               CPU data write strobe
//   data_addr   in   ADDR_W          CPU data address
//   dma_en      in   1               DMA access active
//   dma_addr    in   ADDR_W          DMA address
//   irq         in   1               interrupt taken
//   gie         in   1               SR.GIE
//   reset       out  1               system reset request (registered)
//   viol_cause  out  NUM_REGIONS+3   {atom, gie, irq, rgn[]} of first violation
//   viol_cnt    out  CNT_W           saturating violation-event count
//
// Handshake note: there is no valid/ready traffic here; every input is
// sampled on every rising clk edge and every output changes only on that edge
// (or asynchronously on rst_n).
// ---------------------------------------------------------------------------
module garota_mr
    import garota_mr_pkg::*;
#(
    parameter int                            ADDR_W        = 16,
    parameter int                            NUM_REGIONS   = 4,
    // Region 0 occupies the least significant ADDR_W bits.
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASES  = {16'h0000, 16'h0000, 16'h0080, 16'h0130},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZES  = {16'h0000, 16'h0000, 16'h0010, 16'h00D0},
    parameter logic [ADDR_W-1:0]             TCB_BASE      = 16'hA000,
    parameter logic [ADDR_W-1:0]             TCB_SIZE      = 16'h4000,
    parameter logic [ADDR_W-1:0]             TCB_EXIT      = 16'hDFFE,
    parameter logic [ADDR_W-1:0]             RESET_HANDLER = 16'h0000,
    parameter int                            RST_HOLD      = 4,
    parameter int                            CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     data_wr,
    input  logic [ADDR_W-1:0]        data_addr,
    input  logic                     dma_en,
    input  logic [ADDR_W-1:0]        dma_addr,
    input  logic                     irq,
    input  logic                     gie,
    output logic                     reset,
    output logic [NUM_REGIONS+2:0]   viol_cause,
    output logic [CNT_W-1:0]         viol_cnt
);

    // Hold counter only needs to reach RST_HOLD-1.
    localparam int HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(RST_HOLD - 1);

    // ---------------------------------------------------------------
    // Window compares
    // ---------------------------------------------------------------
    logic [NUM_REGIONS-1:0] wr_hit;
    logic [NUM_REGIONS-1:0] dma_hit;
    logic                   in_tcb;

    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        garota_region_chk #(.ADDR_W(ADDR_W)) u_wr_chk (
            .addr (data_addr),
            .base (REGION_BASES[gi*ADDR_W +: ADDR_W]),
            .size (REGION_SIZES[gi*ADDR_W +: ADDR_W]),
            .hit  (wr_hit[gi])
        );
        garota_region_chk #(.ADDR_W(ADDR_W)) u_dma_chk (
            .addr (dma_addr),
            .base (REGION_BASES[gi*ADDR_W +: ADDR_W]),
            .size (REGION_SIZES[gi*ADDR_W +: ADDR_W]),
            .hit  (dma_hit[gi])
        );
    end

    garota_region_chk #(.ADDR_W(ADDR_W)) u_tcb_chk (
        .addr (pc),
        .base (TCB_BASE),
        .size (TCB_SIZE),
        .hit  (in_tcb)
    );

    // ---------------------------------------------------------------
    // Previous-cycle PC tracking for the atomicity check. Reset values
    // make the first cycle after reset look like "was outside the TCB",
    // so the first cycle can only atom-violate by landing mid-TCB.
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] prev_pc;
    logic              prev_in_tcb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc     <= RESET_HANDLER;
            prev_in_tcb <= 1'b0;
        end else begin
            prev_pc     <= pc;
            prev_in_tcb <= in_tcb;
        end
    end

    // ---------------------------------------------------------------
    // Per-cycle violation terms
    // ---------------------------------------------------------------
    logic [NUM_REGIONS-1:0] rgn_t;
    logic                   irq_t;
    logic                   gie_t;
    logic                   atom_t;
    logic                   viol;

    // Writes from inside the TCB are trusted; DMA never is.
    assign rgn_t  = ({NUM_REGIONS{data_wr & ~in_tcb}} & wr_hit)
                  | ({NUM_REGIONS{dma_en}} & dma_hit);
    assign irq_t  = in_tcb & (irq | dma_en);
    assign gie_t  = in_tcb & gie;
    assign atom_t = (~prev_in_tcb & in_tcb & (pc != TCB_BASE))
                  | (prev_in_tcb & ~in_tcb & (prev_pc != TCB_EXIT));
    assign viol   = (|rgn_t) | irq_t | gie_t | atom_t;

    // ---------------------------------------------------------------
    // Monitor FSM with registered reset output. The state register is
    // kept as a named state_t signal so checkers can bind to it.
    // ---------------------------------------------------------------
    state_t         state;
    logic [HCW-1:0] hold_cnt;
    logic           reset_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ARMED;
            hold_cnt <= '0;
            reset_q  <= 1'b0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (viol) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_LOAD;
                        reset_q  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    reset_q <= 1'b1;
                    if (hold_cnt == '0) begin
                        state <= ST_WAIT_RH;
                    end else begin
                        hold_cnt <= hold_cnt - HCW'(1);
                    end
                end
                ST_WAIT_RH: begin
                    // Release only once the core is back at its reset vector.
                    if (pc == RESET_HANDLER) begin
                        state   <= ST_ARMED;
                        reset_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_ARMED;
                    reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign reset = reset_q;

    // ---------------------------------------------------------------
    // Violation log
    // ---------------------------------------------------------------
`ifdef GAROTA_MR_VIOL_LOG_EN
    logic [NUM_REGIONS+2:0] cause_now;
    logic [NUM_REGIONS+2:0] cause_q;
    logic [CNT_W-1:0]       cnt_q;

    assign cause_now = {atom_t, gie_t, irq_t, rgn_t};

    // Only the ARMED->HOLD transition logs; violations seen while reset is
    // already asserted are consequences, not new events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= '0;
            cnt_q   <= '0;
        end else if ((state == ST_ARMED) && viol) begin
            if (cause_q == '0) begin
                cause_q <= cause_now;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign viol_cause = cause_q;
    assign viol_cnt   = cnt_q;
`else
    assign viol_cause = '0;
    assign viol_cnt   = '0;
`endif

endmodule

// File: tb/tb_garota_mr.sv
// ---------------------------------------------------------------------------
// tb_garota_mr
// Directed bench for garota_mr: a table of single-cycle violation vectors
// (each from a fresh reset, with a priming PC to set up prev_pc), plus
// hand-written sequences for reset hold length, WAIT_RH release, events
// during HOLD, async reset mid-HOLD and counter saturation.
// ---------------------------------------------------------------------------
module tb_garota_mr;

`ifdef GAROTA_MR_VIOL_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    localparam logic [63:0] BASES = {16'h0000, 16'h0000, 16'h0080, 16'h0130};
    localparam logic [63:0] SIZES = {16'h0000, 16'h0000, 16'h0010, 16'h00D0};

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'hE000;
    logic        data_wr = 1'b0;
    logic [15:0] data_addr = '0;
    logic        dma_en = 1'b0;
    logic [15:0] dma_addr = '0;
    logic        irq = 1'b0;
    logic        gie = 1'b0;
    logic        reset;
    logic [6:0]  viol_cause;
    logic [7:0]  viol_cnt;

    always #5 clk = ~clk;

    garota_mr #(
        .ADDR_W        (16),
        .NUM_REGIONS   (4),
        .REGION_BASES  (BASES),
        .REGION_SIZES  (SIZES),
        .TCB_BASE      (16'hA000),
        .TCB_SIZE      (16'h4000),
        .TCB_EXIT      (16'hDFFE),
        .RESET_HANDLER (16'h0000),
        .RST_HOLD      (4),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .dma_en     (dma_en),
        .dma_addr   (dma_addr),
        .irq        (irq),
        .gie        (gie),
        .reset      (reset),
        .viol_cause (viol_cause),
        .viol_cnt   (viol_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        exp_q.push_back(exp);
        check(name, act);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [15:0] p, input logic wr, input logic [15:0] wa,
                         input logic de, input logic [15:0] da, input logic ir, input logic ge);
        pc = p; data_wr = wr; data_addr = wa; dma_en = de; dma_addr = da; irq = ir; gie = ge;
    endtask

    task automatic idle(input logic [15:0] p);
        drive(p, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        idle(16'hE000);
        rst_n = 1'b0;
        @(negedge clk);
        expect_val({tag, "_rst_reset"}, {31'd0, reset}, 32'd0);
        expect_val({tag, "_rst_cnt"}, {24'd0, viol_cnt}, 32'd0);
        rst_n = 1'b1;
    endtask

    function automatic bit tcb_pc(input logic [15:0] p);
        return (p >= 16'hA000) && (p < 16'hE000);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] prev_pc;
        logic [15:0] pc;
        logic        wr;
        logic [15:0] waddr;
        logic        dma;
        logic [15:0] daddr;
        logic        irq;
        logic        gie;
        logic        exp_rst;
        logic [6:0]  exp_cause;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] pp, input logic [15:0] p, input logic wr,
                                input logic [15:0] wa, input logic de, input logic [15:0] da,
                                input logic ir, input logic ge, input logic er, input logic [6:0] ec);
        vec_t v;
        v.prev_pc = pp; v.pc = p; v.wr = wr; v.waddr = wa; v.dma = de; v.daddr = da;
        v.irq = ir; v.gie = ge; v.exp_rst = er; v.exp_cause = ec;
        return v;
    endfunction

    initial begin
        int high_cnt;

        //                 prev      pc        wr  waddr     dma daddr     irq gie rst cause
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h0085, 0, 16'h0000, 0, 0, 1, 7'h02));
        vecs.push_back(mk(16'hA100, 16'hA100, 1, 16'h0085, 0, 16'h0000, 0, 0, 0, 7'h00));
        vecs.push_back(mk(16'hA100, 16'hA100, 0, 16'h0000, 1, 16'h0130, 0, 0, 1, 7'h11));
        vecs.push_back(mk(16'hE000, 16'hE000, 0, 16'h0000, 1, 16'h0130, 0, 0, 1, 7'h01));
        vecs.push_back(mk(16'hE000, 16'hA004, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h40));
        vecs.push_back(mk(16'hE000, 16'hA000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00));
        vecs.push_back(mk(16'hDFFE, 16'hE000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00));
        vecs.push_back(mk(16'hDFF0, 16'hE000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h40));
        vecs.push_back(mk(16'hA000, 16'hA010, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 7'h30));
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h007F, 0, 16'h0000, 0, 0, 0, 7'h00));
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h0080, 0, 16'h0000, 0, 0, 1, 7'h02));
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h008F, 0, 16'h0000, 0, 0, 1, 7'h02));
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h0090, 0, 16'h0000, 0, 0, 0, 7'h00));
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h01FF, 0, 16'h0000, 0, 0, 1, 7'h01));
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h0200, 0, 16'h0000, 0, 0, 0, 7'h00));
        vecs.push_back(mk(16'hE000, 16'hE000, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00));
        vecs.push_back(mk(16'hE000, 16'hE000, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 7'h00));
        vecs.push_back(mk(16'hE000, 16'hDFFF, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h40));
        vecs.push_back(mk(16'hA000, 16'hA000, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 7'h10));
        vecs.push_back(mk(16'hDFFE, 16'hE000, 1, 16'h0085, 0, 16'h0000, 0, 0, 1, 7'h02));
        vecs.push_back(mk(16'hA100, 16'hA100, 0, 16'h0000, 1, 16'h0090, 0, 0, 1, 7'h10));
        vecs.push_back(mk(16'hA100, 16'hA104, 1, 16'h0130, 0, 16'h0000, 0, 0, 0, 7'h00));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_reset(tag);
            // Enter the TCB legally before sitting on an in-TCB prev_pc.
            if (tcb_pc(vecs[i].prev_pc)) begin
                idle(16'hA000);
                @(negedge clk);
            end
            idle(vecs[i].prev_pc);
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].wr, vecs[i].waddr, vecs[i].dma, vecs[i].daddr,
                  vecs[i].irq, vecs[i].gie);
            @(negedge clk);
            expect_val({tag, "_reset"}, {31'd0, reset}, {31'd0, vecs[i].exp_rst});
            expect_val({tag, "_cause"}, {25'd0, viol_cause}, LOG ? {25'd0, vecs[i].exp_cause} : 32'd0);
            expect_val({tag, "_cnt"}, {24'd0, viol_cnt}, (LOG && vecs[i].exp_rst) ? 32'd1 : 32'd0);
        end

        // ---- WAIT_RH hold, HOLD-time violations ignored, release on RESET_HANDLER ----
        do_reset("seq_hold");
        drive(16'hE000, 1'b1, 16'h0085, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        expect_val("hold_latency", {31'd0, reset}, 32'd1);
        high_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            // Keep attacking region 1 while reset is already asserted.
            drive(16'h1234, 1'b1, 16'h0085, 1'b1, 16'h0130, 1'b0, 1'b0);
            @(negedge clk);
            if (reset) high_cnt++;
        end
        expect_val("hold_20_cycles", high_cnt, 32'd20);
        idle(16'h0000);
        @(negedge clk);
        expect_val("release_at_rh", {31'd0, reset}, 32'd0);
        expect_val("hold_cnt_unchanged", {24'd0, viol_cnt}, LOG ? 32'd1 : 32'd0);
        expect_val("hold_cause_unchanged", {25'd0, viol_cause}, LOG ? 32'h02 : 32'd0);

        // Second event: counted, but first cause stays sticky.
        drive(16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0130, 1'b0, 1'b0);
        @(negedge clk);
        expect_val("second_viol_reset", {31'd0, reset}, 32'd1);
        expect_val("second_viol_cnt", {24'd0, viol_cnt}, LOG ? 32'd2 : 32'd0);
        expect_val("second_viol_cause_sticky", {25'd0, viol_cause}, LOG ? 32'h02 : 32'd0);
        // With pc parked at RESET_HANDLER the pulse is the minimum length.
        idle(16'h0000);
        high_cnt = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (reset) high_cnt++;
            else break;
        end
        expect_val("min_reset_len", high_cnt, 32'd5);

        // ---- rst_n low mid-HOLD ----
        do_reset("seq_async");
        drive(16'hE000, 1'b1, 16'h0085, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        idle(16'hE000);
        @(negedge clk);
        expect_val("async_pre_reset", {31'd0, reset}, 32'd1);
        rst_n = 1'b0;
        #1;
        expect_val("async_reset_out", {31'd0, reset}, 32'd0);
        expect_val("async_cnt", {24'd0, viol_cnt}, 32'd0);
        expect_val("async_cause", {25'd0, viol_cause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_val("async_stays_armed", {31'd0, reset}, 32'd0);

        // ---- 300 events: counter saturates ----
        do_reset("seq_sat");
        for (int k = 0; k < 300; k++) begin
            drive(16'h0000, 1'b1, 16'h0085, 1'b0, 16'h0000, 1'b0, 1'b0);
            @(negedge clk);
            idle(16'h0000);
            repeat (6) @(negedge clk);
            if (k == 99) begin
                expect_val("sat_cnt_100", {24'd0, viol_cnt}, LOG ? 32'd100 : 32'd0);
            end
        end
        expect_val("sat_cnt_255", {24'd0, viol_cnt}, LOG ? 32'd255 : 32'd0);
        expect_val("sat_reset_low", {31'd0, reset}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
